mc_ctrl_fsm: RTL and testbench

Multicycle control sequencer for the simplified 16-bit RISC-V datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, handshaking with memory through a req/ready pair. It drives the select addresses of the datapath's word multiplexers (PC source, ALU operands, write-back source, memory address source) and the register write strobes. It sits directly upstream of those multiplexers; every `*_sel` output connects straight to a mux `addr` input.

---
 rtl/mc_ctrl_fsm.sv | 192 +++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit RISC-V datapath.
// Optional performance counters are enabled by defining CTRL_PERF_CNT_EN.
module mc_ctrl_fsm #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       op_class,
   input  logic             br_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             alu_a_sel,
   output logic [1:0]       alu_b_sel,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic [2:0]       state,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] retired,
   output logic [CNT_W-1:0] cycles
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [2:0] OP_RALU   = 3'd0;
   localparam logic [2:0] OP_IALU   = 3'd1;
   localparam logic [2:0] OP_LOAD   = 3'd2;
   localparam logic [2:0] OP_STORE  = 3'd3;
   localparam logic [2:0] OP_BRANCH = 3'd4;
   localparam logic [2:0] OP_JAL    = 3'd5;
   localparam logic [2:0] OP_HALT   = 3'd6;
   localparam logic [2:0] OP_ILL    = 3'd7;

   state_t     r_state;
   state_t     w_next;
   logic       r_err;
   logic       w_set_err;
   logic       w_mem_req;
   logic       w_mem_we;
   logic       w_ir_we;
   logic       w_pc_we;
   logic       w_rf_we;

   // Next-state and select decode; strobes are gated by rst below.
   always_comb begin
      w_next    = r_state;
      w_set_err = 1'b0;
      w_mem_req = 1'b0;
      w_mem_we  = 1'b0;
      w_ir_we   = 1'b0;
      w_pc_we   = 1'b0;
      w_rf_we   = 1'b0;
      addr_sel  = 1'b0;
      pc_sel    = 1'b0;
      alu_a_sel = 1'b0;
      alu_b_sel = 2'd0;
      wb_sel    = 2'd0;
      halted    = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_req = 1'b1;
            if (mem_ready) begin
               w_ir_we = 1'b1;
               w_pc_we = 1'b1;
               w_next  = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 2'd1;
            case (op_class)
               OP_HALT: w_next = S_HALT;
               OP_ILL: begin
                  w_next    = S_HALT;
                  w_set_err = 1'b1;
               end
               default: w_next = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (op_class)
               OP_RALU: w_next = S_WB;
               OP_IALU: begin
                  alu_b_sel = 2'd1;
                  w_next    = S_WB;
               end
               OP_LOAD, OP_STORE: begin
                  alu_b_sel = 2'd1;
                  w_next    = S_MEM;
               end
               OP_BRANCH: begin
                  w_pc_we = br_taken;
                  pc_sel  = br_taken;
                  w_next  = S_FETCH;
               end
               OP_JAL: begin
                  w_pc_we = 1'b1;
                  pc_sel  = 1'b1;
                  w_next  = S_WB;
               end
               default: w_next = S_FETCH;
            endcase
         end
         S_MEM: begin
            w_mem_req = 1'b1;
            addr_sel  = 1'b1;
            w_mem_we  = (op_class == OP_STORE);
            if (mem_ready) begin
               w_next = (op_class == OP_STORE) ? S_FETCH : S_WB;
            end
         end
         S_WB: begin
            w_rf_we = 1'b1;
            if (op_class == OP_LOAD) begin
               wb_sel = 2'd1;
            end else if (op_class == OP_JAL) begin
               wb_sel = 2'd2;
            end
            w_next = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
            w_next = S_HALT;
         end
         default: w_next = S_FETCH;
      endcase
   end

   assign mem_req = w_mem_req & ~rst;
   assign mem_we  = w_mem_we  & ~rst;
   assign ir_we   = w_ir_we   & ~rst;
   assign pc_we   = w_pc_we   & ~rst;
   assign rf_we   = w_rf_we   & ~rst;
   assign state   = r_state;
   assign err     = r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_set_err) begin
            r_err <= 1'b1;
         end
      end
   end

`ifdef CTRL_PERF_CNT_EN
   logic             w_retire;
   logic [CNT_W-1:0] r_retired;
   logic [CNT_W-1:0] r_cycles;

   // An instruction retires on any transition back into FETCH.
   assign w_retire = (r_state == S_WB)
                   | ((r_state == S_MEM)  & mem_ready & (op_class == OP_STORE))
                   | ((r_state == S_EXEC) & (op_class == OP_BRANCH));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_retired <= '0;
         r_cycles  <= '0;
      end else begin
         if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
         end
         if (r_state != S_HALT) begin
            r_cycles <= r_cycles + CNT_W'(1);
         end
      end
   end

   assign retired = r_retired;
   assign cycles  = r_cycles;
`else
   assign retired = '0;
   assign cycles  = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench for mc_ctrl_fsm: per-instruction expected traces built from the phase rules.
module tb_mc_ctrl_fsm;

   localparam int unsigned CNT_W = 4;
`ifdef CTRL_PERF_CNT_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [2:0]       op_class = 3'd0;
   logic             br_taken = 1'b0;
   logic             mem_ready = 1'b0;
   logic             mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_a_sel;
   logic [1:0]       alu_b_sel, wb_sel;
   logic             rf_we, halted, err;
   logic [2:0]       state;
   logic [CNT_W-1:0] retired, cycles;

   mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .op_class(op_class), .br_taken(br_taken),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
      .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we),
      .wb_sel(wb_sel), .state(state), .halted(halted), .err(err),
      .retired(retired), .cycles(cycles)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_a_sel;
      logic [1:0] alu_b_sel;
      logic       rf_we;
      logic [1:0] wb_sel;
      logic       halted, err;
   } obs_t;

   typedef struct packed {
      logic [2:0] op;
      logic       br;
      logic       rdy;
   } drv_t;

   obs_t exp_q[$];
   obs_t obs_q[$];
   drv_t drv_q[$];
   int   errors = 0;
   int   checks = 0;
   int   m_ret  = 0;
   int   m_cyc  = 0;

   function automatic obs_t blank(input logic [2:0] st);
      obs_t o;
      o    = '0;
      o.st = st;
      return o;
   endfunction

   function automatic logic [CNT_W-1:0] exp_cnt(input int v);
      return CNT_W'(v) & {CNT_W{PERF_EN}};
   endfunction

   // Expected per-cycle trace of one instruction, phase by phase.
   task automatic build_plan(input logic [2:0] op, input logic br, input int fw,
                             input int mw, input int halt_n);
      obs_t o;
      for (int k = 0; k <= fw; k++) begin
         o = blank(3'd0);
         o.mem_req = 1'b1;
         if (k == fw) begin
            o.ir_we = 1'b1;
            o.pc_we = 1'b1;
         end
         exp_q.push_back(o);
         drv_q.push_back('{op, br, k == fw});
         m_cyc++;
      end
      o = blank(3'd1);
      o.alu_a_sel = 1'b1;
      o.alu_b_sel = 2'd1;
      exp_q.push_back(o);
      drv_q.push_back('{op, br, 1'b0});
      m_cyc++;
      if (op >= 3'd6) begin
         for (int k = 0; k < halt_n; k++) begin
            o = blank(3'd5);
            o.halted = 1'b1;
            o.err    = (op == 3'd7);
            exp_q.push_back(o);
            drv_q.push_back('{op, br, 1'($urandom)});
         end
         return;
      end
      o = blank(3'd2);
      if (op == 3'd1 || op == 3'd2 || op == 3'd3) o.alu_b_sel = 2'd1;
      if (op == 3'd4) begin
         o.pc_we  = br;
         o.pc_sel = br;
      end
      if (op == 3'd5) begin
         o.pc_we  = 1'b1;
         o.pc_sel = 1'b1;
      end
      exp_q.push_back(o);
      drv_q.push_back('{op, br, 1'b0});
      m_cyc++;
      if (op == 3'd2 || op == 3'd3) begin
         for (int k = 0; k <= mw; k++) begin
            o = blank(3'd3);
            o.mem_req  = 1'b1;
            o.addr_sel = 1'b1;
            o.mem_we   = (op == 3'd3);
            exp_q.push_back(o);
            drv_q.push_back('{op, br, k == mw});
            m_cyc++;
         end
      end
      if (op != 3'd3 && op != 3'd4) begin
         o = blank(3'd4);
         o.rf_we  = 1'b1;
         o.wb_sel = (op == 3'd2) ? 2'd1 : (op == 3'd5) ? 2'd2 : 2'd0;
         exp_q.push_back(o);
         drv_q.push_back('{op, br, 1'b0});
         m_cyc++;
      end
      m_ret++;
   endtask

   // Drives the first n planned cycles and records what the DUT shows in each.
   task automatic play(input int n);
      obs_t o;
      obs_q.delete();
      for (int i = 0; i < n; i++) begin
         op_class  = drv_q[i].op;
         br_taken  = (exp_q[i].st == 3'd2) ? drv_q[i].br : 1'($urandom);
         mem_ready = drv_q[i].rdy;
         @(negedge clk);
         o.st = state;            o.mem_req = mem_req;     o.mem_we = mem_we;
         o.addr_sel = addr_sel;   o.ir_we = ir_we;         o.pc_we = pc_we;
         o.pc_sel = pc_sel;       o.alu_a_sel = alu_a_sel; o.alu_b_sel = alu_b_sel;
         o.rf_we = rf_we;         o.wb_sel = wb_sel;       o.halted = halted;
         o.err = err;
         obs_q.push_back(o);
         @(posedge clk);
         #1;
      end
      mem_ready = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_ret = 0;
      m_cyc = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      op_class = 3'd0;
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({mem_req, ir_we, pc_we, rf_we, mem_we} !== 5'b0) begin
         errors++;
         $display("FAIL reset_strobes: got %b expected 00000",
                  {mem_req, ir_we, pc_we, rf_we, mem_we});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      mem_ready = 1'b0;
      m_ret = 0;
      m_cyc = 0;
      checks++;
      if ({state, halted, err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_state: got state=%0d halted=%b err=%b expected 0/0/0",
                  state, halted, err);
      end
      checks++;
      if (retired !== '0 || cycles !== '0) begin
         errors++;
         $display("FAIL reset_counters: got retired=%0d cycles=%0d expected 0/0",
                  retired, cycles);
      end
   endtask

   task automatic test_ralu();
      build_plan(3'd0, 1'b0, 0, 0, 0);
      play(exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL ralu cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (retired !== exp_cnt(m_ret)) begin
         errors++;
         $display("FAIL ralu_retired: got %0d expected %0d", retired, exp_cnt(m_ret));
      end
      exp_q.delete();
      drv_q.delete();
   endtask

   task automatic test_load_waits();
      build_plan(3'd2, 1'b0, 2, 1, 0);
      play(exp_q.size());
      checks++;
      if (exp_q.size() != 8) begin
         errors++;
         $display("FAIL load_len: got %0d expected 8", exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL load cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete();
      drv_q.delete();
   endtask

   task automatic test_branch_jal();
      build_plan(3'd4, 1'b1, 0, 0, 0);
      build_plan(3'd4, 1'b0, 0, 0, 0);
      build_plan(3'd5, 1'b0, 1, 0, 0);
      play(exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL br_jal cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (retired !== exp_cnt(m_ret) || cycles !== exp_cnt(m_cyc)) begin
         errors++;
         $display("FAIL br_jal_counters: got %0d/%0d expected %0d/%0d",
                  retired, cycles, exp_cnt(m_ret), exp_cnt(m_cyc));
      end
      exp_q.delete();
      drv_q.delete();
   endtask

   task automatic test_random();
      logic [2:0] op;
      for (int n = 0; n < 40; n++) begin
         op = 3'($urandom_range(0, 5));
         build_plan(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 0);
      end
      play(exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL random cyc%0d op=%0d: got %h expected %h",
                     i, drv_q[i].op, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (retired !== exp_cnt(m_ret) || cycles !== exp_cnt(m_cyc)) begin
         errors++;
         $display("FAIL random_counters: got %0d/%0d expected %0d/%0d",
                  retired, cycles, exp_cnt(m_ret), exp_cnt(m_cyc));
      end
      exp_q.delete();
      drv_q.delete();
   endtask

   task automatic test_halt();
      for (int pass = 0; pass < 2; pass++) begin
         build_plan((pass == 0) ? 3'd7 : 3'd6, 1'b0, 1, 0, 20);
         play(exp_q.size());
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL halt%0d cyc%0d: got %h expected %h",
                        pass, i, obs_q[i], exp_q[i]);
            end
         end
         checks++;
         if (retired !== exp_cnt(m_ret) || cycles !== exp_cnt(m_cyc)) begin
            errors++;
            $display("FAIL halt%0d_counters: got %0d/%0d expected %0d/%0d",
                     pass, retired, cycles, exp_cnt(m_ret), exp_cnt(m_cyc));
         end
         exp_q.delete();
         drv_q.delete();
         apply_reset();
         checks++;
         if ({state, halted, err} !== 5'b0) begin
            errors++;
            $display("FAIL halt%0d_release: got state=%0d halted=%b err=%b expected 0/0/0",
                     pass, state, halted, err);
         end
      end
   endtask

   task automatic test_reset_mid_store();
      build_plan(3'd3, 1'b0, 0, 3, 0);
      play(4);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL mid_store cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      rst = 1'b1;
      op_class = 3'd3;
      @(negedge clk);
      checks++;
      if ({state, mem_req, mem_we} !== {3'd3, 2'b00}) begin
         errors++;
         $display("FAIL mid_store_rst: got state=%0d req=%b we=%b expected 3/0/0",
                  state, mem_req, mem_we);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_ret = 0;
      m_cyc = 0;
      checks++;
      if (state !== 3'd0 || retired !== '0 || cycles !== '0) begin
         errors++;
         $display("FAIL mid_store_after: got state=%0d retired=%0d cycles=%0d expected 0/0/0",
                  state, retired, cycles);
      end
      exp_q.delete();
      drv_q.delete();
   endtask

   task automatic test_wrap();
      for (int n = 0; n < 17; n++) build_plan(3'd0, 1'b0, 0, 0, 0);
      play(exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL wrap cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (retired !== exp_cnt(17) || cycles !== exp_cnt(m_cyc)) begin
         errors++;
         $display("FAIL wrap_counters: got %0d/%0d expected %0d/%0d",
                  retired, cycles, exp_cnt(17), exp_cnt(m_cyc));
      end
      exp_q.delete();
      drv_q.delete();
   endtask

   initial begin
      test_reset();
      test_ralu();
      test_load_waits();
      test_branch_jal();
      test_random();
      test_halt();
      test_reset_mid_store();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
